// File: rtl/disp_cmd_if.sv
// Command-byte / character-buffer bus for disp_cmd_decoder.
//   cmd_valid/cmd_data/cmd_ready : byte stream from the FIFO read stage
//   wr_en/wr_addr/wr_data        : one-cycle writes into the char/attr buffer
//   busy                         : screen clear in progress
//   cursor_addr                  : only when DISP_CMD_CURSOR_OUT_EN is defined
// master = byte source / buffer sink, slave = the decoder.
interface disp_cmd_if #(parameter int ADDR_W = 12) ();
  logic              cmd_valid;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
`ifdef DISP_CMD_CURSOR_OUT_EN
  logic [ADDR_W-1:0] cursor_addr;
  modport master (output cmd_valid, cmd_data,
                  input  cmd_ready, wr_en, wr_addr, wr_data, busy, cursor_addr);
  modport slave  (input  cmd_valid, cmd_data,
                  output cmd_ready, wr_en, wr_addr, wr_data, busy, cursor_addr);
`else
  modport master (output cmd_valid, cmd_data,
                  input  cmd_ready, wr_en, wr_addr, wr_data, busy);
  modport slave  (input  cmd_valid, cmd_data,
                  output cmd_ready, wr_en, wr_addr, wr_data, busy);
`endif
endinterface

// File: rtl/disp_cmd_decoder.sv
// Text-terminal command decoder for the VGA character buffer.
// Printable bytes are written at the cursor with the current attribute;
// CR/LF/BS move the cursor; ESC sequences set attribute (ESC A a),
// position (ESC P r c) or clear the screen (ESC C, one cell per cycle).
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - disp_cmd_if.slave (command stream in, buffer writes out, busy)
// Optional: define DISP_CMD_CURSOR_OUT_EN to drive bus.cursor_addr.
module disp_cmd_decoder #(
  parameter int         COLS     = 100,
  parameter int         ROWS     = 37,
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] DEF_ATTR = 8'h07
) (
  input  logic     clk,
  input  logic     rst,
  disp_cmd_if.slave bus
);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CELLS = COLS * ROWS;
  localparam logic [RW-1:0]     ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0]     COL_MAX  = CW'(COLS - 1);
  localparam logic [ADDR_W-1:0] CELL_MAX = ADDR_W'(CELLS - 1);

  typedef enum logic [2:0] {S_NORM, S_ESC, S_ATTR, S_ROW, S_COL, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d, rowt_q, rowt_d;
  logic [CW-1:0]     col_q, col_d;
  logic [7:0]        attr_q, attr_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              ready_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              accept;

  function automatic logic [ADDR_W-1:0] cell_addr(logic [RW-1:0] r, logic [CW-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // ready_q only marks "out of reset"; the clear state masks it.
  assign bus.cmd_ready = ready_q && (state_q != S_CLEAR);
  assign bus.busy      = (state_q == S_CLEAR);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rowt_d    = rowt_q;
    attr_d    = attr_q;
    clr_d     = clr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_NORM: if (accept) begin
        if (bus.cmd_data >= 8'h20 && bus.cmd_data <= 8'h7E) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cell_addr(row_q, col_q);
          wr_data_d = {attr_q, bus.cmd_data};
          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          case (bus.cmd_data)
            8'h0D:   col_d = '0;
            8'h0A:   row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            8'h08:   if (col_q != '0) col_d = col_q - 1'b1;
            8'h1B:   state_d = S_ESC;
            default: ;
          endcase
        end
      end
      S_ESC: if (accept) begin
        case (bus.cmd_data)
          8'h41: state_d = S_ATTR;
          8'h50: state_d = S_ROW;
          8'h43: begin
            state_d = S_CLEAR;
            attr_d  = DEF_ATTR;
            clr_d   = '0;
          end
          default: state_d = S_NORM;
        endcase
      end
      S_ATTR: if (accept) begin
        attr_d  = bus.cmd_data;
        state_d = S_NORM;
      end
      S_ROW: if (accept) begin
        rowt_d  = (int'(bus.cmd_data) >= ROWS) ? ROW_MAX : RW'(bus.cmd_data);
        state_d = S_COL;
      end
      S_COL: if (accept) begin
        // row is held back until here so the cursor moves in one step
        row_d   = rowt_q;
        col_d   = (int'(bus.cmd_data) >= COLS) ? COL_MAX : CW'(bus.cmd_data);
        state_d = S_NORM;
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_q;
        wr_data_d = {DEF_ATTR, 8'h20};
        if (clr_q == CELL_MAX) begin
          state_d = S_NORM;
          row_d   = '0;
          col_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      default: state_d = S_NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_NORM;
      row_q     <= '0;
      col_q     <= '0;
      rowt_q    <= '0;
      attr_q    <= DEF_ATTR;
      clr_q     <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rowt_q    <= rowt_d;
      attr_q    <= attr_d;
      clr_q     <= clr_d;
      ready_q   <= 1'b1;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef DISP_CMD_CURSOR_OUT_EN
  // Follows the committed cursor one cycle later; parked at 0 while clearing.
  logic [ADDR_W-1:0] cursor_q;
  always_ff @(posedge clk) begin
    if (rst || state_q == S_CLEAR) cursor_q <= '0;
    else                           cursor_q <= cell_addr(row_q, col_q);
  end
  assign bus.cursor_addr = cursor_q;
`endif
endmodule

// File: tb/tb_disp_cmd_decoder.sv
module tb_disp_cmd_decoder;
  localparam int         COLS  = 100;
  localparam int         ROWS  = 37;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] DEF   = 8'h07;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_cmd_if #(.ADDR_W(12)) ifc ();
  disp_cmd_decoder #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .DEF_ATTR(DEF))
    dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: linear cursor index plus the raw bytes of any open
  // escape sequence; a sequence is interpreted once it is complete.
  int         m_row, m_col;
  logic [7:0] m_attr;
  logic [7:0] esc[$];

  task automatic model_reset();
    m_row = 0; m_col = 0; m_attr = DEF; esc.delete();
  endtask

  task automatic model_step(input logic [7:0] b, output logic w, output logic [11:0] a,
                            output logic [15:0] d, output bit clr);
    int lin;
    w = 1'b0; a = '0; d = '0; clr = 1'b0;
    if (esc.size() == 0) begin
      if (b >= 8'h20 && b <= 8'h7E) begin
        lin = m_row * COLS + m_col;
        w = 1'b1; a = 12'(lin); d = {m_attr, b};
        lin = (lin + 1) % CELLS;
        m_row = lin / COLS; m_col = lin % COLS;
      end else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h0A) m_row = (m_row + 1) % ROWS;
      else if (b == 8'h08) begin if (m_col > 0) m_col--; end
      else if (b == 8'h1B) esc.push_back(b);
    end else begin
      esc.push_back(b);
      case (esc[1])
        8'h41: if (esc.size() == 3) begin m_attr = esc[2]; esc.delete(); end
        8'h50: if (esc.size() == 4) begin
          m_row = (int'(esc[2]) >= ROWS) ? ROWS - 1 : int'(esc[2]);
          m_col = (int'(esc[3]) >= COLS) ? COLS - 1 : int'(esc[3]);
          esc.delete();
        end
        8'h43: begin clr = 1'b1; m_attr = DEF; m_row = 0; m_col = 0; esc.delete(); end
        default: esc.delete();
      endcase
    end
  endtask

  // Presents a byte, waits (bounded) for acceptance, returns outputs sampled
  // one cycle after the accepting edge.
  task automatic send(input logic [7:0] b, output logic w, output logic [11:0] a,
                      output logic [15:0] d);
    int n = 0;
    ifc.cmd_valid = 1'b1; ifc.cmd_data = b;
    while (!ifc.cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
    if (!ifc.cmd_ready) chk("ready_timeout", 32'(ifc.cmd_ready), 32'd1);
    @(posedge clk); #1;
    w = ifc.wr_en; a = ifc.wr_addr; d = ifc.wr_data;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic run_clear(input int abort);
    int nbusy = 0, nwr = 0, nbad = 0;
    if (ifc.busy) nbusy++;
    if (ifc.wr_en || ifc.cmd_ready) nbad++;
    for (int k = 1; k <= CELLS; k++) begin
      if (k == abort) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wr_en", 32'(ifc.wr_en), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_ready", 32'(ifc.cmd_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_ready", 32'(ifc.cmd_ready), 32'd1);
        chk("partial_clr_bad", 32'(nbad), 32'd0);
        chk("partial_clr_writes", 32'(nwr), 32'(abort - 1));
        model_reset();
        return;
      end
      @(posedge clk); #1;
      if (ifc.busy) nbusy++;
      if (ifc.cmd_ready == ifc.busy) nbad++;
      if (ifc.wr_en) begin
        nwr++;
        if (ifc.wr_addr != 12'(k - 1) || ifc.wr_data != 16'h0720) nbad++;
      end else nbad++;
    end
    @(posedge clk); #1;
    chk("clr_tail_wr_en", 32'(ifc.wr_en), 32'd0);
    chk("clr_tail_busy", 32'(ifc.busy), 32'd0);
    chk("clr_busy_cycles", 32'(nbusy), 32'(CELLS));
    chk("clr_writes", 32'(nwr), 32'(CELLS));
    chk("clr_bad_cycles", 32'(nbad), 32'd0);
  endtask

  // One byte: expected write either given explicitly or taken from the model.
  task automatic put(input string nm, input logic [7:0] b, input bit use_model,
                     input logic ew, input logic [11:0] ea, input logic [15:0] ed,
                     input int abort);
    logic mw, w; logic [11:0] ma, a; logic [15:0] md, d; bit clr;
    model_step(b, mw, ma, md, clr);
    if (use_model) begin ew = mw; ea = ma; ed = md; end
    send(b, w, a, d);
    chk({nm, "_wr_en"}, 32'(w), 32'(ew));
    if (ew) begin
      chk({nm, "_addr"}, 32'(a), 32'(ea));
      chk({nm, "_data"}, 32'(d), 32'(ed));
    end
    if (clr) run_clear(abort);
`ifdef DISP_CMD_CURSOR_OUT_EN
    else begin
      @(posedge clk); #1;
      chk({nm, "_cursor"}, 32'(ifc.cursor_addr), 32'(m_row * COLS + m_col));
      chk({nm, "_pulse"}, 32'(ifc.wr_en), 32'd0);
    end
`endif
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        w;
    logic [11:0] a;
    logic [15:0] d;
  } vec_t;
  vec_t tbl[$];

  function automatic void tv(logic [7:0] b, logic w = 1'b0, logic [11:0] a = '0,
                             logic [15:0] d = '0);
    tbl.push_back('{b, w, a, d});
  endfunction

  initial begin
    logic [7:0] rb;
    ifc.cmd_valid = 1'b0; ifc.cmd_data = '0;
    model_reset();

    tv("H", 1, 0, 16'h0748);     tv("i", 1, 1, 16'h0769);
    tv(8'h1B); tv("P"); tv(8'd5); tv(8'd99);
    tv("X", 1, 599, 16'h0758);   tv("Y", 1, 600, 16'h0759);
    tv(8'h1B); tv("P"); tv(8'd36); tv(8'd99);
    tv("Z", 1, 3699, 16'h075A);  tv("Z", 1, 0, 16'h075A);
    tv(8'h1B); tv("P"); tv(8'd200); tv(8'd200);
    tv("W", 1, 3699, 16'h0757);
    tv(8'h1B); tv("A"); tv(8'h1E);
    tv("Q", 1, 0, 16'h1E51);
    tv(8'h0D); tv(8'h0A); tv(8'h08);
    tv("a", 1, 100, 16'h1E61);
    tv(8'h08);
    tv("b", 1, 100, 16'h1E62);
    // 'Q' is the discarded escape follower; the byte after it is plain text
    tv(8'h1B); tv("Q");
    tv("K", 1, 101, 16'h1E4B);   tv("K", 1, 102, 16'h1E4B);
    tv(8'h15);                   tv(8'h7F);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ifc.cmd_ready), 32'd0);
    chk("reset_wr_en", 32'(ifc.wr_en), 32'd0);
    chk("reset_busy", 32'(ifc.busy), 32'd0);
    chk("reset_addr", 32'(ifc.wr_addr), 32'd0);
    chk("reset_data", 32'(ifc.wr_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(ifc.cmd_ready), 32'd1);

    foreach (tbl[i]) put($sformatf("vec%0d", i), tbl[i].b, 1'b0, tbl[i].w, tbl[i].a, tbl[i].d, 0);

    // full clear, then the attribute and cursor must be back to defaults
    put("clr_esc", 8'h1B, 1'b0, 1'b0, 0, 0, 0);
    put("clr_cmd", "C", 1'b0, 1'b0, 0, 0, 0);
    put("post_clr", "H", 1'b0, 1'b1, 0, 16'h0748, 0);

    // reset 1000 cycles into a clear
    put("pos_esc", 8'h1B, 1'b0, 1'b0, 0, 0, 0);
    put("pos_p", "P", 1'b0, 1'b0, 0, 0, 0);
    put("pos_r", 8'd3, 1'b0, 1'b0, 0, 0, 0);
    put("pos_c", 8'd4, 1'b0, 1'b0, 0, 0, 0);
    put("clr2_esc", 8'h1B, 1'b0, 1'b0, 0, 0, 0);
    put("clr2_cmd", "C", 1'b0, 1'b0, 0, 0, 1000);
    put("post_abort", "K", 1'b0, 1'b1, 0, 16'h074B, 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rb = 8'($urandom_range(32, 126));
        5: rb = ($urandom_range(0, 2) == 0) ? 8'h0D : (($urandom_range(0, 1) == 0) ? 8'h0A : 8'h08);
        6: rb = 8'h1B;
        7: rb = 8'($urandom_range(0, 255));
        8: rb = ($urandom_range(0, 1) == 0) ? 8'h41 : 8'h50;
        default: rb = 8'($urandom_range(0, 120));
      endcase
      put("rnd", rb, 1'b1, 1'b0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("rnd_idle_wr_en", 32'(ifc.wr_en), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
